psum_accumulator: RTL and testbench

Accumulates signed column partial sums from successive crossbar passes (one pass per input-channel chunk), pre-loaded with a per-channel bias, into elementWidth-bit results. Sits directly upstream of the output scaler: its wx_o bus and valid/ready pair feed the scaler's wx_i path. Uses saturating accumulation, a pass counter and a one-entry output register with backpressure.

---
 rtl/psum_pkg.sv | 46 ++++
 rtl/psum_accumulator_sat_add.sv | 33 +++
 rtl/psum_accumulator.sv | 105 ++++++++++
 tb/tb_psum_accumulator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// State encoding, saturation bounds and saturating add.
package psum_pkg;

  localparam int N_ELEM = 4;
  localparam int PART_W = 16;
  localparam int ELEM_W = 20;
  localparam int PASS_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  localparam logic signed [ELEM_W-1:0] MAX_ACC =
    {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic signed [ELEM_W-1:0] MIN_ACC =
    {1'b1, {(ELEM_W-1){1'b0}}};

  typedef struct packed {
    logic signed [ELEM_W-1:0] val;
    logic                     clamp;
  } sat_t;

  // One guard bit is enough: the top two bits of the
  // wide sum disagree exactly when the result overflows.
  function automatic sat_t sat_add(
    input logic signed [ELEM_W-1:0] a,
    input logic signed [PART_W-1:0] p
  );
    logic signed [ELEM_W:0] wide;
    sat_t r;
    wide = {a[ELEM_W-1], a}
         + {{(ELEM_W+1-PART_W){p[PART_W-1]}}, p};
    r.clamp = wide[ELEM_W] ^ wide[ELEM_W-1];
    if (!r.clamp)
      r.val = wide[ELEM_W-1:0];
    else if (wide[ELEM_W])
      r.val = MIN_ACC;
    else
      r.val = MAX_ACC;
    return r;
  endfunction

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// Per-element sign-extend, add, clamp and clamp flag.
// Ports: acc_i, psum_i in; sum_o, clamp_o out.
module psum_sat_add
  import psum_pkg::*;
#(
  parameter int PW = PART_W,
  parameter int EW = ELEM_W
) (
  input  logic [EW-1:0] acc_i,
  input  logic [PW-1:0] psum_i,
  output logic [EW-1:0] sum_o,
  output logic          clamp_o
);

  generate
    if (EW == ELEM_W && PW == PART_W) begin : g_pkg
      sat_t w_r;
      assign w_r     = sat_add(acc_i, psum_i);
      assign sum_o   = w_r.val;
      assign clamp_o = w_r.clamp;
    end else begin : g_gen
      logic [EW:0] w_wide;
      assign w_wide = {acc_i[EW-1], acc_i}
                    + {{(EW+1-PW){psum_i[PW-1]}}, psum_i};
      assign clamp_o = w_wide[EW] ^ w_wide[EW-1];
      assign sum_o =
        !clamp_o   ? w_wide[EW-1:0] :
        w_wide[EW] ? {1'b1, {(EW-1){1'b0}}} :
                     {1'b0, {(EW-1){1'b1}}};
    end
  endgenerate

endmodule

// File: rtl/psum_accumulator.sv
// Bias-preloaded saturating accumulator of crossbar
// partial sums with a one-entry backpressured output.
// Ports: clk, nrst (active-high async), start_i,
// num_passes_i, bias_i, psum_i/valid/ready,
// wx_o/valid/ready, busy_o, overflow_o.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int numElements  = N_ELEM,
  parameter int partialWidth = PART_W,
  parameter int elementWidth = ELEM_W,
  parameter int passBits     = PASS_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic [passBits-1:0]    num_passes_i,
  input  logic [numElements*elementWidth-1:0] bias_i,
  input  logic [numElements*partialWidth-1:0] psum_i,
  input  logic                   psum_valid_i,
  output logic                   psum_ready_o,
  output logic [numElements*elementWidth-1:0] wx_o,
  output logic                   wx_valid_o,
  input  logic                   wx_ready_i,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int AW = numElements * elementWidth;

  state_t              r_state;
  logic [AW-1:0]       r_acc;
  logic [passBits-1:0] r_cnt;
  logic [passBits-1:0] r_num;
  logic                r_ovf;

  logic [AW-1:0]          w_sum;
  logic [numElements-1:0] w_clamp;
  logic                   w_start;
  logic                   w_last;

  genvar g;
  generate
    for (g = 0; g < numElements; g++) begin : g_el
      psum_sat_add #(
        .PW(partialWidth),
        .EW(elementWidth)
      ) u_add (
        .acc_i  (r_acc[g*elementWidth +: elementWidth]),
        .psum_i (psum_i[g*partialWidth +: partialWidth]),
        .sum_o  (w_sum[g*elementWidth +: elementWidth]),
        .clamp_o(w_clamp[g])
      );
    end
  endgenerate

  // A start is taken from IDLE, or from OUT in the same
  // cycle the result leaves, so groups can chain.
  assign w_start = start_i &
    ((r_state == IDLE) ||
     (r_state == OUT && wx_ready_i));

  assign w_last = (r_cnt == r_num - passBits'(1));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_num   <= num_passes_i;
      r_acc   <= bias_i;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_state <= (num_passes_i == '0) ? OUT : ACCUM;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (psum_valid_i) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + passBits'(1);
            if (|w_clamp)
              r_ovf <= 1'b1;
            if (w_last)
              r_state <= OUT;
          end
        end
        OUT: begin
          if (wx_ready_i)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign psum_ready_o = (r_state == ACCUM);
  assign wx_valid_o   = (r_state == OUT);
  assign busy_o       = (r_state != IDLE);
  assign wx_o         = r_acc;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator.
// Hand-computed vectors, one checking task.
module tb_psum_accumulator;

  localparam int NE = 4;
  localparam int PW = 16;
  localparam int EW = 20;
  localparam int PB = 8;

  logic            clk = 1'b0;
  logic            nrst;
  logic            start_i;
  logic [PB-1:0]   num_passes_i;
  logic [NE*EW-1:0] bias_i;
  logic [NE*PW-1:0] psum_i;
  logic            psum_valid_i;
  logic            psum_ready_o;
  logic [NE*EW-1:0] wx_o;
  logic            wx_valid_o;
  logic            wx_ready_i;
  logic            busy_o;
  logic            overflow_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk         (clk),
    .nrst        (nrst),
    .start_i     (start_i),
    .num_passes_i(num_passes_i),
    .bias_i      (bias_i),
    .psum_i      (psum_i),
    .psum_valid_i(psum_valid_i),
    .psum_ready_o(psum_ready_o),
    .wx_o        (wx_o),
    .wx_valid_o  (wx_valid_o),
    .wx_ready_i  (wx_ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NE*EW-1:0] acc4(
    input int a, input int b, input int c, input int d
  );
    logic [NE*EW-1:0] r;
    int v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < NE; i++) r[i*EW +: EW] = v[i][EW-1:0];
    return r;
  endfunction

  function automatic logic [NE*PW-1:0] ps4(
    input int a, input int b, input int c, input int d
  );
    logic [NE*PW-1:0] r;
    int v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < NE; i++) r[i*PW +: PW] = v[i][PW-1:0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b1;
    start_i = 1'b0;
    num_passes_i = '0;
    bias_i = '0;
    psum_i = '0;
    psum_valid_i = 1'b1;
    wx_ready_i = 1'b0;
    step();
    step();
    nrst = 1'b0;
    step();
    check("rst_valid", 128'(wx_valid_o), 128'(0));
    check("rst_ready", 128'(psum_ready_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_ovf", 128'(overflow_o), 128'(0));
    check("rst_wx", 128'(wx_o), 128'(0));
    step();
    step();
    check("idle_ready", 128'(psum_ready_o), 128'(0));
    check("idle_busy", 128'(busy_o), 128'(0));
    psum_valid_i = 1'b0;

    // basic three-pass group
    start_i = 1'b1;
    num_passes_i = 8'd3;
    bias_i = acc4(10, -5, 0, 7);
    step();
    start_i = 1'b0;
    check("b_ready", 128'(psum_ready_o), 128'(1));
    check("b_valid0", 128'(wx_valid_o), 128'(0));
    psum_valid_i = 1'b1;
    psum_i = ps4(1, 2, 3, 4);
    step();
    psum_i = ps4(-1, -1, -1, -1);
    step();
    check("b_mid_valid", 128'(wx_valid_o), 128'(0));
    psum_i = ps4(100, 0, -100, 5);
    step();
    psum_valid_i = 1'b0;
    check("b_valid", 128'(wx_valid_o), 128'(1));
    check("b_wx", 128'(wx_o), 128'(acc4(110, -4, -98, 15)));
    check("b_ovf", 128'(overflow_o), 128'(0));

    // hold output under backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_wx", 128'(wx_o), 128'(acc4(110, -4, -98, 15)));
      check("bp_valid", 128'(wx_valid_o), 128'(1));
      check("bp_ready", 128'(psum_ready_o), 128'(0));
    end

    // chained start into saturation group
    wx_ready_i = 1'b1;
    start_i = 1'b1;
    num_passes_i = 8'd1;
    bias_i = acc4(524280, -524280, 0, 0);
    step();
    start_i = 1'b0;
    wx_ready_i = 1'b0;
    check("ch_ready", 128'(psum_ready_o), 128'(1));
    check("ch_valid", 128'(wx_valid_o), 128'(0));
    psum_valid_i = 1'b1;
    psum_i = ps4(100, -100, 0, 0);
    step();
    psum_valid_i = 1'b0;
    check("s_valid", 128'(wx_valid_o), 128'(1));
    check("s_wx", 128'(wx_o), 128'(acc4(524287, -524288, 0, 0)));
    check("s_ovf", 128'(overflow_o), 128'(1));
    wx_ready_i = 1'b1;
    step();
    wx_ready_i = 1'b0;
    check("s_idle", 128'(busy_o), 128'(0));
    check("s_ovf_hold", 128'(overflow_o), 128'(1));

    // zero-pass group emits bias, consumes nothing
    start_i = 1'b1;
    num_passes_i = 8'd0;
    bias_i = acc4(1, 2, 3, 4);
    psum_valid_i = 1'b1;
    psum_i = ps4(9, 9, 9, 9);
    step();
    start_i = 1'b0;
    check("z_valid", 128'(wx_valid_o), 128'(1));
    check("z_wx", 128'(wx_o), 128'(acc4(1, 2, 3, 4)));
    check("z_ovf", 128'(overflow_o), 128'(0));
    check("z_ready", 128'(psum_ready_o), 128'(0));
    step();
    check("z_wx_hold", 128'(wx_o), 128'(acc4(1, 2, 3, 4)));
    psum_valid_i = 1'b0;
    wx_ready_i = 1'b1;
    step();
    wx_ready_i = 1'b0;
    check("z_idle", 128'(busy_o), 128'(0));

    // reset aborts a four-pass group after two passes
    start_i = 1'b1;
    num_passes_i = 8'd4;
    bias_i = acc4(0, 0, 0, 0);
    step();
    start_i = 1'b0;
    psum_valid_i = 1'b1;
    psum_i = ps4(3, 3, 3, 3);
    step();
    step();
    psum_valid_i = 1'b0;
    nrst = 1'b1;
    #1;
    check("r_busy", 128'(busy_o), 128'(0));
    check("r_valid", 128'(wx_valid_o), 128'(0));
    check("r_wx", 128'(wx_o), 128'(0));
    step();
    nrst = 1'b0;
    step();
    check("r_valid2", 128'(wx_valid_o), 128'(0));

    // fresh group after abort
    start_i = 1'b1;
    num_passes_i = 8'd2;
    bias_i = acc4(5, 5, 5, 5);
    step();
    start_i = 1'b0;
    psum_valid_i = 1'b1;
    psum_i = ps4(1, 2, 3, 4);
    step();
    psum_i = ps4(-1, -1, -1, -1);
    step();
    psum_valid_i = 1'b0;
    check("f_valid", 128'(wx_valid_o), 128'(1));
    check("f_wx", 128'(wx_o), 128'(acc4(5, 6, 7, 8)));
    check("f_ovf", 128'(overflow_o), 128'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
